// File: rtl/fifo_defs.sv
// Shared definitions for the synchronous FIFO: default geometry, width helpers
// and the decoded per-cycle operation record.
package fifo_defs;

  localparam int DEFAULT_WIDTH  = 10;
  localparam int DEFAULT_LENGHT = 8;
  localparam int DEFAULT_AF_TH  = 6;
  localparam int DEFAULT_AE_TH  = 2;

  // Decoded outcome of one cycle's push/pop requests against the current occupancy.
  typedef struct packed {
    logic push;
    logic pop;
    logic ovf;
    logic unf;
  } fifo_op_t;

  // Ceiling log2, used to size pointers (depth is a power of two, so this is exact).
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Simple dual-port RAM: one write port and one registered read port with
// independent addresses. The read register holds its value between reads.
module fifo_mem_2p
  import fifo_defs::*;
#(
  parameter int  WIDTH = DEFAULT_WIDTH,
  parameter int  DEPTH = DEFAULT_LENGHT,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array; contents survive reset, only the control state is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read; reads see the old word when the same address is written this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO: pointer, occupancy and flag control around
// a dual-port RAM, with sticky overflow/underflow error reporting.
module fifo_sync_param
  import fifo_defs::*;
#(
  parameter int  MEM_WIDTH       = DEFAULT_WIDTH,
  parameter int  MEM_LENGHT      = DEFAULT_LENGHT,
  parameter int  ALMOST_FULL_TH  = DEFAULT_AF_TH,
  parameter int  ALMOST_EMPTY_TH = DEFAULT_AE_TH,
  localparam int ADDR_W          = clog2(MEM_LENGHT),
  localparam int CNT_W           = ADDR_W + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [MEM_WIDTH-1:0] fifo_Data_in,
  input  logic                 write_enable,
  input  logic                 read_enable,
  output logic [MEM_WIDTH-1:0] fifo_Data_out,
  output logic                 data_valid,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [CNT_W-1:0]     count,
  output logic                 overflow,
  output logic                 underflow
);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              overflow_q;
  logic              underflow_q;
  logic              data_valid_q;
  fifo_op_t          op;

  // Decide which requests are accepted; a pop frees the slot a same-cycle push needs when full.
  always_comb begin
    op     = '0;
    op.pop  = read_enable && !empty;
    op.push = write_enable && (!full || read_enable);
    op.ovf  = write_enable && full && !read_enable;
    op.unf  = read_enable && empty;
  end

  fifo_mem_2p #(
    .WIDTH (MEM_WIDTH),
    .DEPTH (MEM_LENGHT)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (op.push && !reset),
    .wr_addr (wr_ptr),
    .wr_data (fifo_Data_in),
    .rd_en   (op.pop && !reset),
    .rd_addr (rd_ptr),
    .rd_data (fifo_Data_out)
  );

  // Pointers advance on accepted operations and wrap naturally at the depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (op.push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (op.pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
    end
  end

  // Occupancy tracks the net effect of the cycle; push+pop together leaves it unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      case ({op.push, op.pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Error flags latch on the first offending request and only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (op.ovf) begin
        overflow_q <= 1'b1;
      end
      if (op.unf) begin
        underflow_q <= 1'b1;
      end
    end
  end

  // data_valid marks the single cycle in which a freshly popped word sits on the output.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_valid_q <= 1'b0;
    end else begin
      data_valid_q <= op.pop;
    end
  end

  assign count        = count_q;
  assign full         = (count_q == CNT_W'(MEM_LENGHT));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CNT_W'(ALMOST_FULL_TH));
  assign almost_empty = (count_q <= CNT_W'(ALMOST_EMPTY_TH));
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign data_valid   = data_valid_q;

endmodule
